// File: rtl/cpu_ctrl_fsm.sv
// Multicycle Moore control FSM for the Simple RISC Machine datapath.
// Define CTRL_TIMEOUT_EN to add the memory-wait timeout and FAULT state.
module cpu_ctrl_fsm #(
    parameter int BR_EXT      = 1,
    parameter int MEM_TIMEOUT = 15,
    parameter int TMO_W       = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [2:0] branch_condition,
    input  logic       Z,
    input  logic       N,
    input  logic       V,
    input  logic       mem_ready,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       write,
    output logic [1:0] asel,
    output logic [1:0] bsel,
    output logic [1:0] vsel,
    output logic [2:0] nsel,
    output logic       load_pc,
    output logic       load_ir,
    output logic       load_addr,
    output logic       addr_sel,
    output logic [1:0] sel_pc,
    output logic [1:0] mem_cmd,
    output logic       ALUop_zero,
    output logic       w,
    output logic       illegal,
    output logic       fault
);

    typedef enum logic [4:0] {
        S_RESET, S_IF_REQ, S_IF_LOAD, S_PC_INC, S_DECODE, S_WR_IMM,
        S_LD_B, S_EXE_B, S_LD_A, S_EXE_AB, S_WB,
        S_ADDR_CALC, S_ADDR_LD, S_MEM_RD, S_MEM_WB, S_ST_B, S_ST_C, S_MEM_WR,
        S_BL_LINK, S_BR_CALC, S_BR_LOAD, S_BX_B, S_BLX_LINK, S_BX_C,
        S_ILLEGAL, S_HALT, S_FAULT
    } state_t;

    if ((1 << TMO_W) <= MEM_TIMEOUT) begin : g_tmo_width_check
        $error("TMO_W too narrow to hold MEM_TIMEOUT");
    end

    state_t     state_q, state_d;
    logic [4:0] ins;
    logic       is_movmvn, is_ldst, is_ldr, is_cmp, is_bx;
    logic       br_legal, br_taken;
    logic       tmo_hit;

    assign ins       = {opcode, op};
    assign is_movmvn = (ins == 5'b11000) || (ins == 5'b10111);
    assign is_ldst   = (ins == 5'b01100) || (ins == 5'b10000);
    assign is_ldr    = (ins == 5'b01100);
    assign is_cmp    = (ins == 5'b10101);
    assign is_bx     = (ins == 5'b01000);

`ifdef CTRL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             waiting;

    // Any cycle outside a stalled wait clears the count, so every wait starts at zero.
    assign waiting = ((state_q == S_IF_REQ) || (state_q == S_MEM_RD) ||
                      (state_q == S_MEM_WR)) && !mem_ready;
    assign tmo_hit = waiting && ((tmo_q + 1'b1) == TMO_W'(MEM_TIMEOUT));
    assign tmo_d   = waiting ? tmo_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (rst) tmo_q <= '0;
        else     tmo_q <= tmo_d;
    end
`else
    localparam bit TMO_EN = 1'b0;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (branch_condition)
            3'b000: br_taken = 1'b1;
            3'b001: br_taken = Z;
            3'b010: br_taken = !Z;
            3'b011: br_taken = N ^ V;
            3'b100: br_taken = (N ^ V) | Z;
            3'b101: begin br_legal = (BR_EXT != 0); br_taken = !(N ^ V); end
            3'b110: begin br_legal = (BR_EXT != 0); br_taken = !(N ^ V) & !Z; end
            default: br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_RESET;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET:   state_d = S_IF_REQ;
            S_IF_REQ:  if (mem_ready) state_d = S_IF_LOAD;
                       else if (tmo_hit) state_d = S_FAULT;
            S_IF_LOAD: state_d = S_PC_INC;
            S_PC_INC:  state_d = S_DECODE;
            S_DECODE: begin
                if (opcode == 3'b001)
                    state_d = !br_legal ? S_ILLEGAL : (br_taken ? S_BR_CALC : S_IF_REQ);
                else if (opcode == 3'b111)
                    state_d = S_HALT;
                else begin
                    case (ins)
                        5'b11010:                   state_d = S_WR_IMM;
                        5'b11000, 5'b10111, 5'b10100,
                        5'b10101, 5'b10110:         state_d = S_LD_B;
                        5'b01100, 5'b10000:         state_d = S_LD_A;
                        5'b01011:                   state_d = S_BL_LINK;
                        5'b01000, 5'b01010:         state_d = S_BX_B;
                        default:                    state_d = S_ILLEGAL;
                    endcase
                end
            end
            S_WR_IMM:    state_d = S_IF_REQ;
            S_LD_B:      state_d = is_movmvn ? S_EXE_B : S_LD_A;
            S_EXE_B:     state_d = S_WB;
            S_LD_A:      state_d = is_ldst ? S_ADDR_CALC : S_EXE_AB;
            S_EXE_AB:    state_d = is_cmp ? S_IF_REQ : S_WB;
            S_WB:        state_d = S_IF_REQ;
            S_ADDR_CALC: state_d = S_ADDR_LD;
            S_ADDR_LD:   state_d = is_ldr ? S_MEM_RD : S_ST_B;
            S_MEM_RD:    if (mem_ready) state_d = S_MEM_WB;
                         else if (tmo_hit) state_d = S_FAULT;
            S_MEM_WB:    state_d = S_IF_REQ;
            S_ST_B:      state_d = S_ST_C;
            S_ST_C:      state_d = S_MEM_WR;
            S_MEM_WR:    if (mem_ready) state_d = S_IF_REQ;
                         else if (tmo_hit) state_d = S_FAULT;
            S_BL_LINK:   state_d = S_BR_CALC;
            S_BR_CALC:   state_d = S_BR_LOAD;
            S_BR_LOAD:   state_d = S_IF_REQ;
            S_BX_B:      state_d = is_bx ? S_BX_C : S_BLX_LINK;
            S_BLX_LINK:  state_d = S_BX_C;
            S_BX_C:      state_d = S_BR_LOAD;
            S_ILLEGAL:   state_d = S_IF_REQ;
            S_HALT:      state_d = S_HALT;
            S_FAULT:     state_d = S_FAULT;
            default:     state_d = S_RESET;
        endcase
    end

    always_comb begin
        loada = 1'b0; loadb = 1'b0; loadc = 1'b0; loads = 1'b0; write = 1'b0;
        asel = 2'b00; bsel = 2'b00; vsel = 2'b00; nsel = 3'b000;
        load_pc = 1'b0; load_ir = 1'b0; load_addr = 1'b0; addr_sel = 1'b0;
        sel_pc = 2'b00; mem_cmd = 2'b00; ALUop_zero = 1'b0;
        w = 1'b0; illegal = 1'b0; fault = 1'b0;
        case (state_q)
            S_RESET:     load_pc = 1'b1;
            S_IF_REQ:    begin addr_sel = 1'b1; mem_cmd = 2'b01; end
            S_IF_LOAD:   begin addr_sel = 1'b1; mem_cmd = 2'b01; load_ir = 1'b1; end
            S_PC_INC:    begin load_pc = 1'b1; sel_pc = 2'b01; end
            S_WR_IMM:    begin nsel = 3'b001; vsel = 2'b10; write = 1'b1; end
            S_LD_B:      begin nsel = 3'b100; loadb = 1'b1; end
            S_EXE_B:     begin asel = 2'b01; loadc = 1'b1; end
            S_LD_A:      begin nsel = 3'b001; loada = 1'b1; end
            S_EXE_AB:    if (is_cmp) loads = 1'b1; else loadc = 1'b1;
            S_WB:        begin nsel = 3'b010; write = 1'b1; end
            S_ADDR_CALC: begin bsel = 2'b01; loadc = 1'b1; end
            S_ADDR_LD:   load_addr = 1'b1;
            S_MEM_RD:    mem_cmd = 2'b01;
            S_MEM_WB:    begin mem_cmd = 2'b01; vsel = 2'b01; nsel = 3'b010; write = 1'b1; end
            S_ST_B:      begin nsel = 3'b010; loadb = 1'b1; end
            S_ST_C:      begin asel = 2'b01; loadc = 1'b1; end
            S_MEM_WR:    mem_cmd = 2'b10;
            S_BL_LINK:   begin vsel = 2'b11; nsel = 3'b001; write = 1'b1; ALUop_zero = 1'b1; end
            S_BR_CALC:   begin asel = 2'b10; bsel = 2'b10; loadc = 1'b1; end
            S_BR_LOAD:   begin sel_pc = 2'b10; load_pc = 1'b1; end
            S_BX_B:      begin nsel = 3'b010; loadb = 1'b1; end
            S_BLX_LINK:  begin vsel = 2'b11; nsel = 3'b001; write = 1'b1; end
            S_BX_C:      begin asel = 2'b01; loadc = 1'b1; end
            S_ILLEGAL:   illegal = 1'b1;
            S_HALT:      w = 1'b1;
            S_FAULT:     begin w = 1'b1; fault = TMO_EN; end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Randomized bench for cpu_ctrl_fsm: a per-instruction step model predicts every cycle's outputs.
module tb_cpu_ctrl_fsm;

    localparam int BR_EXT_TB = 0;

    typedef struct packed {
        logic       loada, loadb, loadc, loads, write;
        logic [1:0] asel, bsel, vsel;
        logic [2:0] nsel;
        logic       load_pc, load_ir, load_addr, addr_sel;
        logic [1:0] sel_pc, mem_cmd;
        logic       aluz, w, illegal, fault;
    } outs_t;

    logic       clk = 1'b0, rst = 1'b1;
    logic [2:0] opcode = '0, branch_condition = '0;
    logic [1:0] op = '0;
    logic       Z = 1'b0, N = 1'b0, V = 1'b0, mem_ready = 1'b0;
    logic       loada, loadb, loadc, loads, write;
    logic [1:0] asel, bsel, vsel, sel_pc, mem_cmd;
    logic [2:0] nsel;
    logic       load_pc, load_ir, load_addr, addr_sel, ALUop_zero, w, illegal, fault;
    outs_t      dut_o;

    int checks = 0, errors = 0;
    string q_n[$];
    bit    q_m[$];
    logic [2:0] p_opc, p_cond;
    logic [1:0] p_op;
    logic       p_z, p_n, p_v;

    cpu_ctrl_fsm #(.BR_EXT(BR_EXT_TB), .MEM_TIMEOUT(15), .TMO_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .op(op), .branch_condition(branch_condition),
        .Z(Z), .N(N), .V(V), .mem_ready(mem_ready),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads), .write(write),
        .asel(asel), .bsel(bsel), .vsel(vsel), .nsel(nsel),
        .load_pc(load_pc), .load_ir(load_ir), .load_addr(load_addr), .addr_sel(addr_sel),
        .sel_pc(sel_pc), .mem_cmd(mem_cmd), .ALUop_zero(ALUop_zero),
        .w(w), .illegal(illegal), .fault(fault)
    );

    always #5 clk = ~clk;

    assign dut_o = {loada, loadb, loadc, loads, write, asel, bsel, vsel, nsel,
                    load_pc, load_ir, load_addr, addr_sel, sel_pc, mem_cmd,
                    ALUop_zero, w, illegal, fault};

    // Output table for each named step of the instruction flow.
    function automatic outs_t so(input string n);
        outs_t o;
        o = '0;
        case (n)
            "RESET":     o.load_pc = 1;
            "IF_REQ":    begin o.addr_sel = 1; o.mem_cmd = 2'b01; end
            "IF_LOAD":   begin o.addr_sel = 1; o.mem_cmd = 2'b01; o.load_ir = 1; end
            "PC_INC":    begin o.load_pc = 1; o.sel_pc = 2'b01; end
            "DECODE":    ;
            "WR_IMM":    begin o.nsel = 3'b001; o.vsel = 2'b10; o.write = 1; end
            "LD_B":      begin o.nsel = 3'b100; o.loadb = 1; end
            "EXE_B":     begin o.asel = 2'b01; o.loadc = 1; end
            "LD_A":      begin o.nsel = 3'b001; o.loada = 1; end
            "EXE_CMP":   o.loads = 1;
            "EXE_AB":    o.loadc = 1;
            "WB":        begin o.nsel = 3'b010; o.write = 1; end
            "ADDR_CALC": begin o.bsel = 2'b01; o.loadc = 1; end
            "ADDR_LD":   o.load_addr = 1;
            "MEM_RD":    o.mem_cmd = 2'b01;
            "MEM_WB":    begin o.mem_cmd = 2'b01; o.vsel = 2'b01; o.nsel = 3'b010; o.write = 1; end
            "ST_B":      begin o.nsel = 3'b010; o.loadb = 1; end
            "ST_C":      begin o.asel = 2'b01; o.loadc = 1; end
            "MEM_WR":    o.mem_cmd = 2'b10;
            "BL_LINK":   begin o.vsel = 2'b11; o.nsel = 3'b001; o.write = 1; o.aluz = 1; end
            "BR_CALC":   begin o.asel = 2'b10; o.bsel = 2'b10; o.loadc = 1; end
            "BR_LOAD":   begin o.sel_pc = 2'b10; o.load_pc = 1; end
            "BX_B":      begin o.nsel = 3'b010; o.loadb = 1; end
            "BLX_LINK":  begin o.vsel = 2'b11; o.nsel = 3'b001; o.write = 1; end
            "BX_C":      begin o.asel = 2'b01; o.loadc = 1; end
            "ILLEGAL":   o.illegal = 1;
            "HALT":      o.w = 1;
            "FAULT":     begin o.w = 1; o.fault = 1; end
            default:     o = '1;
        endcase
        return o;
    endfunction

    task automatic add(input string n, input bit m);
        q_n.push_back(n);
        q_m.push_back(m);
    endtask

    task automatic add_wait(input string n, input int k);
        for (int i = 0; i < k; i++) add(n, 1'b0);
        add(n, 1'b1);
    endtask

    task automatic add_any(input string n);
        add(n, 1'($urandom_range(0, 1)));
    endtask

    // Expected step list for one instruction, derived from the instruction-level rules.
    task automatic build(input logic [2:0] opc, input logic [1:0] o, input logic [2:0] c,
                         input logic z, input logic n, input logic v,
                         input int wif, input int wmem);
        bit legal, taken;
        p_opc = opc; p_op = o; p_cond = c; p_z = z; p_n = n; p_v = v;
        add_wait("IF_REQ", wif);
        add_any("IF_LOAD"); add_any("PC_INC"); add_any("DECODE");
        if (opc == 3'b001) begin
            legal = 1; taken = 0;
            case (c)
                3'd0: taken = 1;
                3'd1: taken = z;
                3'd2: taken = !z;
                3'd3: taken = (n != v);
                3'd4: taken = (n != v) || z;
                3'd5: begin legal = (BR_EXT_TB != 0); taken = (n == v); end
                3'd6: begin legal = (BR_EXT_TB != 0); taken = (n == v) && !z; end
                default: legal = 0;
            endcase
            if (!legal) add_any("ILLEGAL");
            else if (taken) begin add_any("BR_CALC"); add_any("BR_LOAD"); end
        end else if (opc == 3'b111) begin
            add_any("HALT");
        end else begin
            case ({opc, o})
                5'b11010: add_any("WR_IMM");
                5'b11000, 5'b10111: begin add_any("LD_B"); add_any("EXE_B"); add_any("WB"); end
                5'b10100, 5'b10110: begin add_any("LD_B"); add_any("LD_A"); add_any("EXE_AB"); add_any("WB"); end
                5'b10101: begin add_any("LD_B"); add_any("LD_A"); add_any("EXE_CMP"); end
                5'b01100: begin
                    add_any("LD_A"); add_any("ADDR_CALC"); add_any("ADDR_LD");
                    add_wait("MEM_RD", wmem); add_any("MEM_WB");
                end
                5'b10000: begin
                    add_any("LD_A"); add_any("ADDR_CALC"); add_any("ADDR_LD");
                    add_any("ST_B"); add_any("ST_C"); add_wait("MEM_WR", wmem);
                end
                5'b01011: begin add_any("BL_LINK"); add_any("BR_CALC"); add_any("BR_LOAD"); end
                5'b01000: begin add_any("BX_B"); add_any("BX_C"); add_any("BR_LOAD"); end
                5'b01010: begin add_any("BX_B"); add_any("BLX_LINK"); add_any("BX_C"); add_any("BR_LOAD"); end
                default:  add_any("ILLEGAL");
            endcase
        end
    endtask

    // Instruction fields change only on the first step, while the DUT sits in IF_REQ.
    task automatic play(input string tag, input int limit);
        int i;
        i = 0;
        while (q_n.size() > 0 && (limit < 0 || i < limit)) begin
            string n;
            bit    m;
            outs_t exp_o;
            n = q_n.pop_front();
            m = q_m.pop_front();
            exp_o = so(n);
            @(negedge clk);
            if (i == 0) begin
                opcode = p_opc; op = p_op; branch_condition = p_cond;
                Z = p_z; N = p_n; V = p_v;
            end
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL %s step%0d %s: got %h want %h", tag, i, n, dut_o, exp_o);
            end
            mem_ready = m;
            i++;
        end
        q_n.delete();
        q_m.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        mem_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        checks++;
        if (dut_o !== so("RESET")) begin
            errors++;
            $display("FAIL reset: got %h want %h", dut_o, so("RESET"));
        end
        rst = 1'b0;
    endtask

    task automatic test_mov_imm();
        build(3'b110, 2'b10, 3'b000, 0, 0, 0, 0, 0);
        play("mov_imm", -1);
    endtask

    task automatic test_fetch_wait();
        build(3'b110, 2'b10, 3'b000, 0, 0, 0, 3, 0);
        play("fetch_wait", -1);
    endtask

    task automatic test_cmp_branch();
        build(3'b101, 2'b01, 3'b000, 0, 1, 0, 0, 0);
        play("cmp", -1);
        build(3'b001, 2'b00, 3'b011, 0, 1, 0, 0, 0);
        play("blt_taken", -1);
        build(3'b001, 2'b00, 3'b011, 0, 0, 0, 0, 0);
        play("blt_not_taken", -1);
    endtask

    task automatic test_blx_bge();
        build(3'b010, 2'b10, 3'b000, 0, 0, 0, 0, 0);
        play("blx", -1);
        build(3'b001, 2'b00, 3'b101, 0, 0, 0, 0, 0);
        play("bge_illegal", -1);
        build(3'b001, 2'b00, 3'b110, 0, 0, 0, 1, 0);
        play("bgt_illegal", -1);
    endtask

    task automatic test_str_rst_midwait();
        build(3'b100, 2'b00, 3'b000, 0, 0, 0, 0, 2);
        play("str_wait", -1);
        build(3'b011, 2'b00, 3'b000, 0, 0, 0, 1, 2);
        play("ldr_wait", -1);
        build(3'b100, 2'b00, 3'b000, 0, 0, 0, 0, 5);
        play("str_midwait", 11);
        test_reset();
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            logic [2:0] opc;
            opc = 3'($urandom_range(0, 6));
            build(opc, 2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  $urandom_range(0, 3), $urandom_range(0, 3));
            play("random", -1);
        end
    endtask

    task automatic test_halt();
        build(3'b111, 2'($urandom), 3'($urandom), 0, 0, 0, 0, 0);
        play("halt", -1);
        for (int k = 0; k < 10; k++) add_any("HALT");
        play("halt_hold", -1);
        test_reset();
    endtask

`ifdef CTRL_TIMEOUT_EN
    task automatic test_timeout();
        build(3'b110, 2'b10, 3'b000, 0, 0, 0, 14, 0);
        play("tmo_ready_wins", -1);
        for (int k = 0; k < 15; k++) add("IF_REQ", 1'b0);
        for (int k = 0; k < 8; k++) add_any("FAULT");
        play("tmo_fault", -1);
        test_reset();
    endtask
`endif

    initial begin
        test_reset();
        test_mov_imm();
        test_fetch_wait();
        test_cmp_branch();
        test_blx_bge();
        test_str_rst_midwait();
        test_random();
`ifdef CTRL_TIMEOUT_EN
        test_timeout();
`endif
        test_halt();
        test_mov_imm();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
